// File: rtl/score_controller.sv
`default_nettype none
// ============================================================================
//  Module   : score_controller
//  Purpose  : Turns hit/miss/scrolled-past pulses into score, streak,
//             multiplier, best streak and a rock meter, and sequences the
//             song state (idle, playing, failed, cleared) for the HUD.
//  Revision : 1.0  initial release
// ============================================================================
module score_controller #(
    parameter int SCORE_W     = 20,
    parameter int STREAK_W    = 10,
    parameter int BASE_POINTS = 50,
    parameter int STEP        = 10,
    parameter int MULT_MAX    = 4,
    parameter int METER_MAX   = 255,
    parameter int METER_INIT  = 128,
    parameter int METER_UP    = 4,
    parameter int METER_DOWN  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_game,
    input  logic                song_end,
    input  logic                hit_event,
    input  logic                miss_event,
    input  logic                note_missed,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak,
    output logic [STREAK_W-1:0] best_streak,
    output logic [2:0]          multiplier,
    output logic [7:0]          rock_meter,
    output logic                playing,
    output logic                game_over,
    output logic                song_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_FAILED  = 2'd2,
        S_CLEARED = 2'd3
    } state_t;

    localparam logic [SCORE_W:0]    c_BASE_PTS   = (SCORE_W+1)'(BASE_POINTS);
    localparam logic [STREAK_W-1:0] c_STEP       = STREAK_W'(STEP);
    localparam logic [STREAK_W-1:0] c_MULT_STEPS = STREAK_W'(MULT_MAX - 1);
    localparam logic [8:0]          c_METER_MAX  = 9'(METER_MAX);
    localparam logic [8:0]          c_METER_UP   = 9'(METER_UP);
    localparam logic [8:0]          c_METER_DOWN = 9'(METER_DOWN);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_clear;
    logic                 w_process;

    logic [SCORE_W-1:0]   r_score;
    logic [STREAK_W-1:0]  r_streak;
    logic [STREAK_W-1:0]  r_best;
    logic [2:0]           r_mult;
    logic [7:0]           r_meter;
    logic                 r_playing;
    logic                 r_game_over;
    logic                 r_song_done;

    logic                 w_miss;
    logic [SCORE_W:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_next;
    logic [STREAK_W:0]    w_streak_inc;
    logic [STREAK_W-1:0]  w_streak_next;
    logic [STREAK_W-1:0]  w_best_next;
    logic [STREAK_W-1:0]  w_steps;
    logic [2:0]           w_mult_next;
    logic [8:0]           w_meter_up;
    logic [8:0]           w_meter_hit;
    logic [8:0]           w_meter_next;

    // Event arithmetic: every sum is one bit wider than its register, then clamped.
    always_comb begin
        w_miss       = miss_event | note_missed;

        // Hit points use the multiplier in force before this hit.
        w_score_sum  = {1'b0, r_score} + c_BASE_PTS * (SCORE_W+1)'(r_mult);
        w_score_next = r_score;
        if (hit_event) begin
            w_score_next = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
        end

        w_streak_inc  = {1'b0, r_streak} + 1'b1;
        w_streak_next = r_streak;
        if (w_miss) begin
            w_streak_next = '0;
        end else if (hit_event) begin
            w_streak_next = w_streak_inc[STREAK_W] ? {STREAK_W{1'b1}} : w_streak_inc[STREAK_W-1:0];
        end

        w_best_next = (w_streak_next > r_best) ? w_streak_next : r_best;

        // Multiplier tracks the streak it is registered with.
        w_steps     = w_streak_next / c_STEP;
        w_mult_next = (w_steps >= c_MULT_STEPS) ? 3'(MULT_MAX) : 3'(w_steps + 1'b1);

        // A simultaneous hit and miss applies the gain first, then the loss.
        w_meter_up  = {1'b0, r_meter} + c_METER_UP;
        w_meter_hit = {1'b0, r_meter};
        if (hit_event) begin
            w_meter_hit = (w_meter_up > c_METER_MAX) ? c_METER_MAX : w_meter_up;
        end
        w_meter_next = w_meter_hit;
        if (w_miss) begin
            w_meter_next = (w_meter_hit >= c_METER_DOWN) ? (w_meter_hit - c_METER_DOWN) : 9'd0;
        end
    end

    // Game state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a drained meter takes priority over the end of the chart.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_process    = 1'b0;
        case (r_state)
            S_PLAYING: begin
                w_process = 1'b1;
                if (w_miss && (w_meter_next == 9'd0)) begin
                    w_state_next = S_FAILED;
                end else if (song_end) begin
                    w_state_next = S_CLEARED;
                end
            end
            default: begin
                if (start_game) begin
                    w_clear      = 1'b1;
                    w_state_next = S_PLAYING;
                end
            end
        endcase
    end

    // Counters and status flags; frozen outside of play.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_score     <= '0;
            r_streak    <= '0;
            r_best      <= '0;
            r_mult      <= 3'd1;
            r_meter     <= 8'(METER_INIT);
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            if (w_clear) begin
                r_score  <= '0;
                r_streak <= '0;
                r_best   <= '0;
                r_mult   <= 3'd1;
                r_meter  <= 8'(METER_INIT);
            end else if (w_process) begin
                r_score  <= w_score_next;
                r_streak <= w_streak_next;
                r_best   <= w_best_next;
                r_mult   <= w_mult_next;
                r_meter  <= 8'(w_meter_next);
            end
            r_playing   <= (w_state_next == S_PLAYING);
            r_game_over <= (w_state_next == S_FAILED);
            r_song_done <= (w_state_next == S_CLEARED);
        end
    end

    assign score       = r_score;
    assign streak      = r_streak;
    assign best_streak = r_best;
    assign multiplier  = r_mult;
    assign rock_meter  = r_meter;
    assign playing     = r_playing;
    assign game_over   = r_game_over;
    assign song_done   = r_song_done;

endmodule
`default_nettype wire
